modadder_arbiter: RTL and testbench
===================================

# modadder_arbiter

Round-robin arbiter and sequencer that shares one modular adder/subtractor (381-bit operands, start/done handshake) between up to NREQ requesters in the ECDSA verify datapath. Typical requesters are the point-add, point-double and scalar-loop control units. The block:
- latches one requester's operands and drives the adder's start pulse;
- holds operands stable until the adder's done;
- returns the result to the winning requester with a one-cycle response pulse.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 381: operand/result width
- TIMEOUT, 64: watchdog limit in WAIT cycles (used only with the macro)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  level request per requester; held until that requester's rsp_valid
- req_a  in  NREQ*W  operand a; requester i at [i*W +: W]
- req_b  in  NREQ*W  operand b; same slicing
- req_sub  in  NREQ  1 = subtract, 0 = add
- mod_m  in  W  shared modulus; must be stable while busy
- gnt  out  NREQ  one-hot grant, high from ISSUE through RESP
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse
- rsp_result  out  W  result register, valid when any rsp_valid is high
- rsp_err  out  1  high with rsp_valid on a watchdog abort
- busy  out  1  high in every state except IDLE
- ma_start  out  1  one-cycle start pulse to the adder
- ma_a, ma_b, ma_m  out  W  registered operands and modulus to the adder
- ma_sub  out  1  registered subtract select
- ma_done  in  1  adder completion pulse
- ma_result  in  W  adder result, valid while ma_done = 1

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Winner = first asserted req at or after pointer ptr, searching upward modulo NREQ.
  - If any req is set, on the clock edge:
    - latch req_a/req_b/req_sub slices of the winner into ma_a/ma_b/ma_sub, and mod_m into ma_m;
    - set gnt one-hot;
    - go to ISSUE.
- **ISSUE:** ma_start = 1 for exactly this cycle, then go to WAIT.
- **WAIT:**
  - Hold ma_a/ma_b/ma_m/ma_sub constant. The adder samples the modulus and subtract select late, so they must not change mid-operation.
  - On a cycle with ma_done = 1: capture ma_result into rsp_result and go to RESP.
- **ma_done outside WAIT:** ignored. The adder's minimum latency is 2 cycles after start, so it cannot legally arrive in ISSUE.
- **RESP:**
  - rsp_valid[g] = 1 for one cycle.
  - ptr <= (g+1) mod NREQ.
  - Clear gnt and go to IDLE.
- **Fairness:** any requester waits at most NREQ-1 other operations.
- **Request dropped after grant:** the operation completes and rsp_valid is still pulsed. Requesters must not drop req.
- **New requests during busy:** not sampled until the next IDLE cycle.
- **Operands:** W bits, passed unmodified. Caller guarantees a, b < m.
- **rsp_result:** holds its last captured value until the next capture.

## Timing
- **Reset values** (reset high at an edge forces these; any in-flight adder result is discarded):
  - state = IDLE, ptr = 0;
  - gnt, rsp_valid, ma_start, ma_sub, rsp_err, busy = 0;
  - ma_a, ma_b, ma_m, rsp_result = 0.
- **Reset mid-operation:** the adder must be reset from the same source, inverted to its active-low reset.
- **Cycle-level latency**, with req first seen at edge k (IDLE) and the adder latency L ≥ 2 cycles from start:
  - gnt rises after edge k;
  - ma_start is high during cycle k+1;
  - ma_done arrives at cycle k+1+L;
  - rsp_valid is high in cycle k+2+L.
- **Throughput:** one operation per L+3 cycles. An IDLE cycle separates back-to-back operations.
- **busy:** equals (state != IDLE) and is registered.

## Configuration
- **Macro:** MODADDER_ARB_WATCHDOG_EN.
- **When defined:**
  - a counter clears on entry to WAIT and increments each WAIT cycle without ma_done;
  - on reaching TIMEOUT, go to RESP with rsp_result = 0 and rsp_err = 1 alongside rsp_valid;
  - the adder is then assumed hung and needs reset by the system.
- **When undefined:**
  - WAIT persists indefinitely;
  - rsp_err is tied to 0;
  - no counter logic is present.

## Test plan
- **Single add:** req[0] with a=5, b=9, m=13, sub=0, adder model L=2:
  - ma_start high 1 cycle after req;
  - rsp_valid[0] 4 cycles after req;
  - rsp_result=1.
- **Subtract wrap:** req[2] with a=3, b=5, m=13, sub=1 -> rsp_result=11. ma_m and ma_sub stable throughout WAIT.
- **Round-robin:** req=4'b1111 held continuously, each requester deasserting after its response:
  - response order 0,1,2,3;
  - then req=4'b1001 with ptr=0 -> order 0,3.
- **Drop request:** deassert req[1] during WAIT -> rsp_valid[1] still pulses once with the correct result, and no second grant.
- **Reset:** assert reset in WAIT -> next cycle all outputs zero, state IDLE, no rsp_valid; the following request proceeds normally.
- **Watchdog** (macro defined, TIMEOUT=64, ma_done never asserted):
  - rsp_valid and rsp_err pulse 64 cycles after the first WAIT cycle;
  - rsp_result=0.

Source files
------------

// File: rtl/modadder_arbiter.sv
// Round-robin arbiter/sequencer sharing one 381-bit modular adder between NREQ requesters.
// Optional adder watchdog (rsp_err on timeout) is enabled by defining MODADDER_ARB_WATCHDOG_EN.
module modadder_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 381,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  input  logic [W-1:0]      mod_m,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_err,
  output logic              busy,
  output logic              ma_start,
  output logic [W-1:0]      ma_a,
  output logic [W-1:0]      ma_b,
  output logic [W-1:0]      ma_m,
  output logic              ma_sub,
  input  logic              ma_done,
  input  logic [W-1:0]      ma_result
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, sel_q, sel_d;
  logic [IW-1:0]   win_idx, cand_idx;
  int              cand;
  logic            win_found, any_req, wait_done;
  logic [NREQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic            ma_start_q, ma_start_d, ma_sub_q, ma_sub_d, busy_q, busy_d;
  logic [W-1:0]    ma_a_q, ma_a_d, ma_b_q, ma_b_d, ma_m_q, ma_m_d;
  logic [W-1:0]    rsp_result_q, rsp_result_d;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign a_arr[g] = req_a[g*W +: W];
    assign b_arr[g] = req_b[g*W +: W];
  end

  assign any_req = |req;

  // Winner is the first asserted request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

`ifdef MODADDER_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_expired, rsp_err_q;

  assign wd_expired = (state_q == WAIT) && !ma_done && (wd_cnt_q == WDW'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == WAIT && !ma_done) wd_cnt_d = wd_cnt_q + WDW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      rsp_err_q <= wd_expired;
    end
  end

  assign rsp_err   = rsp_err_q;
  assign wait_done = ma_done || wd_expired;
`else
  assign rsp_err   = 1'b0;
  assign wait_done = ma_done;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured only on grant so the adder sees them frozen until done.
  always_comb begin
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    ma_a_d       = ma_a_q;
    ma_b_d       = ma_b_q;
    ma_m_d       = ma_m_q;
    ma_sub_d     = ma_sub_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = '0;
    ma_start_d   = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d      = win_idx;
          gnt_d      = NREQ'(1) << win_idx;
          ma_a_d     = a_arr[win_idx];
          ma_b_d     = b_arr[win_idx];
          ma_sub_d   = req_sub[win_idx];
          ma_m_d     = mod_m;
          ma_start_d = 1'b1;
        end
      end
      WAIT: begin
        if (wait_done) begin
          rsp_valid_d  = gnt_q;
          rsp_result_d = ma_done ? ma_result : '0;
        end
      end
      RESP: begin
        gnt_d = '0;
        if (sel_q == IW'(NREQ - 1)) ptr_d = '0;
        else                        ptr_d = sel_q + IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      sel_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      ma_start_q   <= 1'b0;
      ma_sub_q     <= 1'b0;
      busy_q       <= 1'b0;
      ma_a_q       <= '0;
      ma_b_q       <= '0;
      ma_m_q       <= '0;
      rsp_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      ma_start_q   <= ma_start_d;
      ma_sub_q     <= ma_sub_d;
      busy_q       <= busy_d;
      ma_a_q       <= ma_a_d;
      ma_b_q       <= ma_b_d;
      ma_m_q       <= ma_m_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;
  assign ma_start   = ma_start_q;
  assign ma_a       = ma_a_q;
  assign ma_b       = ma_b_q;
  assign ma_m       = ma_m_q;
  assign ma_sub     = ma_sub_q;

endmodule

// File: tb/tb_modadder_arbiter.sv
// Self-checking bench for modadder_arbiter: transaction-level timeline model plus directed vectors.
// Watchdog vectors are included when MODADDER_ARB_WATCHDOG_EN is defined.
module tb_modadder_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 381;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req, req_sub, gnt, rsp_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      mod_m, rsp_result, ma_a, ma_b, ma_m, ma_result;
  logic              rsp_err, busy, ma_start, ma_sub, ma_done;
  logic              adder_hang;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic checking = 1'b0;

  modadder_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .mod_m(mod_m), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy), .ma_start(ma_start),
    .ma_a(ma_a), .ma_b(ma_b), .ma_m(ma_m), .ma_sub(ma_sub), .ma_done(ma_done),
    .ma_result(ma_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] modop(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] m, input logic sub);
    logic [W:0] s;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end else if (a >= b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return s[W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Adder stand-in: answers LAT cycles after start unless told to hang; reset drops any pending result.
  int         ad_cnt = 0;
  logic [W-1:0] ad_res;
  always @(negedge clk) begin
    ma_done = 1'b0;
    if (reset) begin
      ad_cnt = 0;
    end else begin
      if (ad_cnt > 0) begin
        ad_cnt--;
        if (ad_cnt == 0) begin
          ma_done   = 1'b1;
          ma_result = ad_res;
        end
      end
      if (ma_start && !adder_hang) begin
        ad_cnt = LAT;
        ad_res = modop(ma_a, ma_b, ma_m, ma_sub);
      end
    end
  end

  // Timeline model: m_t counts cycles since grant (-1 idle); grant cycle+1 issues, RESP at m_rt.
  int           m_t = -1, m_win = 0, m_ptr = 0, m_rt = LAT + 1;
  logic [W-1:0] m_a = '0, m_b = '0, m_m = '0, m_exp = '0, m_res = '0;
  logic         m_sub = 1'b0, m_hang = 1'b0;

  always @(posedge clk) begin : model
    logic [NREQ-1:0] rot;
    logic            found;
    int              c;
    if (reset) begin
      m_t = -1; m_ptr = 0; m_win = 0; m_a = '0; m_b = '0; m_m = '0;
      m_sub = 1'b0; m_res = '0; m_hang = 1'b0; m_rt = LAT + 1;
      checking = 1'b1;
    end else if (m_t >= 0 && m_t == m_rt) begin
      m_t   = -1;
      m_ptr = (m_win + 1) % NREQ;
    end else if (m_t >= 0) begin
      m_t++;
      if (m_t == m_rt) m_res = m_hang ? '0 : m_exp;
    end else if (req != '0) begin
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        c   = (m_ptr + i) % NREQ;
        rot = req >> c;
        if (!found && rot[0]) begin
          m_win = c;
          found = 1'b1;
        end
      end
      m_a    = W'(req_a >> (m_win * W));
      m_b    = W'(req_b >> (m_win * W));
      rot    = req_sub >> m_win;
      m_sub  = rot[0];
      m_m    = mod_m;
      m_hang = adder_hang;
      m_exp  = modop(m_a, m_b, m_m, m_sub);
      m_rt   = m_hang ? TIMEOUT + 1 : LAT + 1;
      m_t    = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] eg, ev;
    if (checking) begin
      eg = (m_t >= 0) ? (NREQ'(1) << m_win) : '0;
      ev = (m_t >= 0 && m_t == m_rt) ? eg : '0;
      checkOutput("gnt", W'(gnt), W'(eg));
      checkOutput("rsp_valid", W'(rsp_valid), W'(ev));
      checkOutput("busy", W'(busy), W'(m_t >= 0));
      checkOutput("ma_start", W'(ma_start), W'(m_t == 0));
      checkOutput("rsp_err", W'(rsp_err), W'(m_t >= 0 && m_t == m_rt && m_hang));
      checkOutput("rsp_result", rsp_result, m_res);
      checkOutput("ma_a", ma_a, m_a);
      checkOutput("ma_b", ma_b, m_b);
      checkOutput("ma_m", ma_m, m_m);
      checkOutput("ma_sub", W'(ma_sub), W'(m_sub));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub);
    logic [NREQ*W-1:0] mask;
    mask    = (NREQ*W)'({W{1'b1}}) << (idx * W);
    req_a   = (req_a & ~mask) | ((NREQ*W)'(a) << (idx * W));
    req_b   = (req_b & ~mask) | ((NREQ*W)'(b) << (idx * W));
    req_sub = (req_sub & ~(NREQ'(1) << idx)) | (NREQ'(sub) << idx);
    req     = req | (NREQ'(1) << idx);
  endtask

  task automatic waitStart(output int at);
    at = -1;
    for (int n = 0; n < 20 && at < 0; n++) begin
      @(negedge clk);
      if (ma_start) at = cyc;
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL start_timeout: ma_start not seen in 20 cycles, expected a pulse");
    end
  endtask

  // Waits for any response, then the winning requester withdraws its request.
  task automatic waitAny(input int budget, output int idx, output int at,
                         output logic [W-1:0] res, output logic err);
    logic [NREQ-1:0] v;
    idx = -1; at = -1; res = '0; err = 1'b0;
    for (int n = 0; n < budget && at < 0; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        at  = cyc;
        res = rsp_result;
        err = rsp_err;
        for (int i = 0; i < NREQ; i++) begin
          v = rsp_valid >> i;
          if (v[0]) idx = i;
        end
      end
    end
    #1;
    if (idx >= 0) req = req & ~(NREQ'(1) << idx);
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL rsp_timeout: no rsp_valid within %0d cycles, expected one", budget);
    end
  endtask

  task automatic doReset();
    tick();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  int           c0, s, r, idx, n_seen;
  logic [W-1:0] res, big;
  logic         err;
  int           rr_idx [4] = '{0, 1, 2, 3};
  int           rr_res [4] = '{3, 9, 4, 9};

  initial begin
    reset = 1'b1; req = '0; req_a = '0; req_b = '0; req_sub = '0; mod_m = '0;
    adder_hang = 1'b0; ma_done = 1'b0; ma_result = '0;
    repeat (2) @(posedge clk);
    tick();
    reset = 1'b0;
    checkOutput("reset_busy", W'(busy), '0);
    checkOutput("reset_gnt", W'(gnt), '0);
    checkOutput("reset_rsp_result", rsp_result, '0);

    $display("[TB] single add on requester 0");
    tick();
    mod_m = 13;
    c0 = cyc;
    applyStimulus(0, 5, 9, 1'b0);
    waitStart(s);
    waitAny(10, idx, r, res, err);
    checkOutput("add_start_latency", W'(s - c0), W'(1));
    checkOutput("add_rsp_latency", W'(r - c0), W'(4));
    checkOutput("add_rsp_index", W'(idx), W'(0));
    checkOutput("add_result", res, W'(1));

    $display("[TB] subtract with wrap on requester 2");
    tick();
    c0 = cyc;
    applyStimulus(2, 3, 5, 1'b1);
    waitStart(s);
    tick();
    mod_m   = 7;
    req_sub = '0;
    waitAny(10, idx, r, res, err);
    checkOutput("sub_rsp_index", W'(idx), W'(2));
    checkOutput("sub_rsp_latency", W'(r - c0), W'(4));
    checkOutput("sub_result", res, W'(11));
    tick();
    mod_m = 13;

    $display("[TB] round robin with all requesters");
    doReset();
    applyStimulus(0, 1, 2, 1'b0);
    applyStimulus(1, 4, 5, 1'b0);
    applyStimulus(2, 7, 3, 1'b1);
    applyStimulus(3, 2, 6, 1'b1);
    for (int k = 0; k < 4; k++) begin
      waitAny(12, idx, r, res, err);
      checkOutput($sformatf("rr_order_%0d", k), W'(idx), W'(rr_idx[k]));
      checkOutput($sformatf("rr_result_%0d", k), res, W'(rr_res[k]));
    end
    tick();
    applyStimulus(0, 6, 6, 1'b0);
    applyStimulus(3, 12, 1, 1'b0);
    waitAny(12, idx, r, res, err);
    checkOutput("rr2_first", W'(idx), W'(0));
    checkOutput("rr2_first_result", res, W'(12));
    waitAny(12, idx, r, res, err);
    checkOutput("rr2_second", W'(idx), W'(3));
    checkOutput("rr2_second_result", res, W'(0));

    $display("[TB] request dropped during wait, full-width operands");
    tick();
    big   = '1;
    mod_m = big;
    applyStimulus(1, big - 1, big - 2, 1'b0);
    waitStart(s);
    tick();
    req[1] = 1'b0;
    waitAny(10, idx, r, res, err);
    checkOutput("drop_rsp_index", W'(idx), W'(1));
    checkOutput("drop_rsp_latency", W'(r - s), W'(3));
    checkOutput("drop_result", res, {{(W-8){1'b1}}, 8'hFC});
    n_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt != '0) n_seen++;
    end
    checkOutput("drop_no_regrant", W'(n_seen), '0);

    $display("[TB] reset during wait");
    tick();
    mod_m = 13;
    applyStimulus(3, 12, 12, 1'b0);
    waitStart(s);
    tick();
    reset = 1'b1;
    req   = '0;
    tick();
    checkOutput("rst_gnt", W'(gnt), '0);
    checkOutput("rst_busy", W'(busy), '0);
    checkOutput("rst_rsp_valid", W'(rsp_valid), '0);
    checkOutput("rst_ma_a", ma_a, '0);
    checkOutput("rst_ma_m", ma_m, '0);
    checkOutput("rst_rsp_result", rsp_result, '0);
    reset = 1'b0;
    n_seen = 0;
    repeat (4) begin
      tick();
      if (rsp_valid != '0) n_seen++;
    end
    checkOutput("rst_no_late_rsp", W'(n_seen), '0);
    c0 = cyc;
    applyStimulus(3, 12, 12, 1'b0);
    waitStart(s);
    waitAny(10, idx, r, res, err);
    checkOutput("post_rst_index", W'(idx), W'(3));
    checkOutput("post_rst_latency", W'(r - c0), W'(4));
    checkOutput("post_rst_result", res, W'(11));

`ifdef MODADDER_ARB_WATCHDOG_EN
    $display("[TB] watchdog with hung adder");
    doReset();
    adder_hang = 1'b1;
    applyStimulus(0, 1, 1, 1'b0);
    waitStart(s);
    waitAny(80, idx, r, res, err);
    checkOutput("wd_index", W'(idx), W'(0));
    checkOutput("wd_latency", W'(r - (s + 1)), W'(64));
    checkOutput("wd_err", W'(err), W'(1));
    checkOutput("wd_result", res, '0);
    adder_hang = 1'b0;
    doReset();
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at time limit");
    $fatal(1, "[TB] aborting");
  end

endmodule
